ysyx_24100029_icache: RTL and testbench

- Direct-mapped instruction cache between the IFU's AXI4 read channel and the system AXI4 crossbar.
- IFU-side: single-beat AXI4 read slave.
  - Hits return in 2 cycles.
  - Misses refill one whole line with an INCR burst on the memory-side AXI4 read master.
- Provides fence_i invalidation and hit/miss performance counters.

---
 rtl/ysyx_24100029_icache_if.sv | 36 +++
 rtl/ysyx_24100029_icache.sv | 139 +++++++++++++
 tb/tb_ysyx_24100029_icache.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100029_icache_if.sv
// Read-channel bundles for the instruction cache: single-beat IFU link and
// the burst-capable memory-side link.
interface ysyx_24100029_icache_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (output arvalid, araddr, rready,
                  input  arready, rvalid, rdata, rresp, rlast);
  modport slave  (input  arvalid, araddr, rready,
                  output arready, rvalid, rdata, rresp, rlast);
endinterface

interface ysyx_24100029_icache_mem_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (output arvalid, araddr, arlen, arsize, arburst, rready,
                  input  arready, rvalid, rdata, rresp, rlast);
  modport slave  (input  arvalid, araddr, arlen, arsize, arburst, rready,
                  output arready, rvalid, rdata, rresp, rlast);
endinterface

// File: rtl/ysyx_24100029_icache.sv
// Direct-mapped instruction cache: single-beat IFU read slave, INCR-burst line
// refill on the memory side, fence_i invalidation and hit/miss counters.
module ysyx_24100029_icache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fence_i,
  ysyx_24100029_icache_if.slave        s,
  ysyx_24100029_icache_mem_if.master   m,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
);
  localparam int unsigned OFF   = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX - OFF;
  localparam int unsigned WB    = OFF - 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] MISS_AR = 3'd2;
  localparam logic [2:0] MISS_R  = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]       state;
  logic [31:0]      addr_q;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];
  logic [WB-1:0]    beat_q;
  logic             err_q;
  logic             fence_seen_q;
  logic [1:0]       rresp_q;
  logic [31:0]      rdata_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   req_idx;
  logic [WB-1:0]    req_word;
  logic             hit;
  logic             last_beat;
  logic             refill_ok;
  logic             unused_addr_lsb;

  assign req_tag  = addr_q[31:IDX+OFF];
  assign req_idx  = addr_q[IDX+OFF-1:OFF];
  assign req_word = addr_q[OFF-1:2];
  // Fetches are word aligned; the byte offset carries no information.
  assign unused_addr_lsb = ^addr_q[1:0];

  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = m.rvalid && (m.rlast || (beat_q == WB'(LINE_WORDS - 1)));
  assign refill_ok = !err_q && (m.rresp == 2'b00) && !fence_seen_q;

  assign s.arready = (state == IDLE);
  assign s.rvalid  = (state == RESP);
  assign s.rlast   = (state == RESP);
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  assign m.arvalid = (state == MISS_AR);
  assign m.araddr  = {addr_q[31:OFF], {OFF{1'b0}}};
  assign m.arlen   = 8'(LINE_WORDS - 1);
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign m.rready  = (state == MISS_R);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_seen_q <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.arvalid) begin
            addr_q <= s.araddr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rdata_q <= data_mem[req_idx][req_word];
            rresp_q <= 2'b00;
            hit_cnt <= hit_cnt + 32'd1;
            state   <= RESP;
          end else begin
            miss_cnt     <= miss_cnt + 32'd1;
            err_q        <= 1'b0;
            rresp_q      <= 2'b00;
            fence_seen_q <= 1'b0;
            state        <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (fence_i) fence_seen_q <= 1'b1;
          if (m.arready) begin
            beat_q <= '0;
            state  <= MISS_R;
          end
        end
        MISS_R: begin
          if (fence_i) fence_seen_q <= 1'b1;
          if (m.rvalid) begin
            beat_q <= beat_q + WB'(1);
            if (beat_q == req_word) rdata_q <= m.rdata;
            if (m.rresp != 2'b00) begin
              err_q <= 1'b1;
              if (!err_q) rresp_q <= m.rresp;
            end
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          if (s.rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A fence in the same cycle as the final beat wins over validation.
      if (fence_i) valid_q <= '0;
      else if ((state == MISS_R) && last_beat && refill_ok) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if ((state == MISS_R) && m.rvalid) begin
      data_mem[req_idx][beat_q] <= m.rdata;
      if (last_beat) tag_mem[req_idx] <= req_tag;
    end
  end
endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Directed bench for ysyx_24100029_icache: vector table of reads against a
// behavioural burst memory, plus an asynchronous reset mid-refill sequence.
module tb_ysyx_24100029_icache;
  logic        clock;
  logic        reset;
  logic        fence_i;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  ysyx_24100029_icache_if     ifu ();
  ysyx_24100029_icache_mem_if mem ();

  ysyx_24100029_icache #(.LINE_WORDS(4), .SETS(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .fence_i  (fence_i),
    .s        (ifu),
    .m        (mem),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    int          err_beat;
    int          fence_beat;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          exp_miss;
    logic [31:0] exp_araddr;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int          ar_delay   = 0;
  int          err_beat   = -1;
  int          fence_beat = -1;
  int          ar_count;
  int          ar_unstable;
  int          cur_beat;
  logic [31:0] ar_addr_last;
  logic [7:0]  ar_len_last;
  logic [2:0]  ar_size_last;
  logic [1:0]  ar_burst_last;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h3000000) begin
      case (a[3:2])
        2'd0:    w = 32'h11;
        2'd1:    w = 32'h22;
        2'd2:    w = 32'h33;
        default: w = 32'h44;
      endcase
    end else begin
      w = a + 32'h1000_0000;
    end
    return w;
  endfunction

  // Behavioural memory: accepts one burst, delays arready, returns 4 beats.
  initial begin
    mem.arready = 1'b0;
    mem.rvalid  = 1'b0;
    mem.rdata   = '0;
    mem.rresp   = '0;
    mem.rlast   = 1'b0;
    fence_i     = 1'b0;
    ar_count    = 0;
    ar_unstable = 0;
    cur_beat    = -1;
    forever begin
      @(posedge clock); #1;
      if (reset && mem.arvalid) begin
        ar_count++;
        ar_addr_last  = mem.araddr;
        ar_len_last   = mem.arlen;
        ar_size_last  = mem.arsize;
        ar_burst_last = mem.arburst;
        for (int i = 0; i < ar_delay; i++) begin
          @(posedge clock); #1;
          if (!mem.arvalid || mem.araddr !== ar_addr_last) ar_unstable++;
        end
        mem.arready = 1'b1;
        @(posedge clock); #1;
        mem.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
          cur_beat    = b;
          mem.rvalid  = 1'b1;
          mem.rdata   = mem_word(ar_addr_last + 32'(4 * b));
          mem.rresp   = (b == err_beat) ? 2'b10 : 2'b00;
          mem.rlast   = (b == 3);
          fence_i     = (b == fence_beat);
          @(posedge clock); #1;
          fence_i = 1'b0;
          if (!reset) break;
        end
        cur_beat   = -1;
        mem.rvalid = 1'b0;
        mem.rlast  = 1'b0;
        mem.rresp  = '0;
      end
    end
  end

  // Called at posedge+1 with the cache idle; returns at posedge+1.
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    int ar_before;
    int unstable_before;
    ar_delay        = v.ar_delay;
    err_beat        = v.err_beat;
    fence_beat      = v.fence_beat;
    ar_before       = ar_count;
    unstable_before = ar_unstable;
    ifu.araddr  = v.addr;
    ifu.arvalid = 1'b1;
    n = 0;
    while (!ifu.arready && n < 50) begin @(posedge clock); #1; n++; end
    check("arready", 32'(ifu.arready), 32'd1);
    @(posedge clock); #1;
    ifu.arvalid = 1'b0;
    lat = 1;
    while (!ifu.rvalid && lat < 200) begin @(posedge clock); #1; lat++; end
    check("rvalid", 32'(ifu.rvalid), 32'd1);
    check("latency", 32'(lat), v.exp_miss ? 32'(7 + v.ar_delay) : 32'd2);
    check("rlast", 32'(ifu.rlast), 32'd1);
    check("rdata", ifu.rdata, v.exp_data);
    check("rresp", 32'(ifu.rresp), 32'(v.exp_resp));
    check("refill_issued", 32'(ar_count - ar_before), v.exp_miss ? 32'd1 : 32'd0);
    if (v.exp_miss) begin
      check("m_araddr", ar_addr_last, v.exp_araddr);
      check("m_arlen", 32'(ar_len_last), 32'd3);
      check("m_arsize", 32'(ar_size_last), 32'd2);
      check("m_arburst", 32'(ar_burst_last), 32'd1);
      check("ar_stable", 32'(ar_unstable - unstable_before), 32'd0);
    end
    check("hit_cnt", hit_cnt, 32'(v.exp_hits));
    check("miss_cnt", miss_cnt, 32'(v.exp_misses));
    // Stall one cycle with rready low: response must hold.
    @(posedge clock); #1;
    check("rvalid_hold", 32'(ifu.rvalid), 32'd1);
    check("rdata_hold", ifu.rdata, v.exp_data);
    check("rresp_hold", 32'(ifu.rresp), 32'(v.exp_resp));
    ifu.rready = 1'b1;
    @(posedge clock); #1;
    ifu.rready = 1'b0;
    check("rvalid_drop", 32'(ifu.rvalid), 32'd0);
    err_beat   = -1;
    fence_beat = -1;
  endtask

  vec_t vecs[14];
  vec_t post[2];

  initial begin
    int n;
    vecs[0]  = '{32'h30000008, 2, -1, -1, 32'h00000033, 2'b00, 1'b1, 32'h30000000, 0, 1};
    vecs[1]  = '{32'h3000000C, 0, -1, -1, 32'h00000044, 2'b00, 1'b0, 32'h0,        1, 1};
    vecs[2]  = '{32'h30000100, 0, -1, -1, 32'h40000100, 2'b00, 1'b1, 32'h30000100, 1, 2};
    vecs[3]  = '{32'h30000000, 0, -1, -1, 32'h00000011, 2'b00, 1'b1, 32'h30000000, 1, 3};
    vecs[4]  = '{32'h30000014, 1, -1, -1, 32'h40000014, 2'b00, 1'b1, 32'h30000010, 1, 4};
    vecs[5]  = '{32'h30000010, 0, -1, -1, 32'h40000010, 2'b00, 1'b0, 32'h0,        2, 4};
    vecs[6]  = '{32'h30000028, 0,  2, -1, 32'h40000028, 2'b10, 1'b1, 32'h30000020, 2, 5};
    vecs[7]  = '{32'h30000028, 0, -1, -1, 32'h40000028, 2'b00, 1'b1, 32'h30000020, 2, 6};
    vecs[8]  = '{32'h3000002C, 0, -1, -1, 32'h4000002C, 2'b00, 1'b0, 32'h0,        3, 6};
    vecs[9]  = '{32'h30000034, 0, -1,  1, 32'h40000034, 2'b00, 1'b1, 32'h30000030, 3, 7};
    vecs[10] = '{32'h30000034, 0, -1, -1, 32'h40000034, 2'b00, 1'b1, 32'h30000030, 3, 8};
    vecs[11] = '{32'h30000000, 0, -1, -1, 32'h00000011, 2'b00, 1'b1, 32'h30000000, 3, 9};
    vecs[12] = '{32'h30000010, 0, -1, -1, 32'h40000010, 2'b00, 1'b1, 32'h30000010, 3, 10};
    vecs[13] = '{32'h30000018, 0, -1, -1, 32'h40000018, 2'b00, 1'b0, 32'h0,        4, 10};
    post[0]  = '{32'h30000040, 0, -1, -1, 32'h40000040, 2'b00, 1'b1, 32'h30000040, 0, 1};
    post[1]  = '{32'h3000002C, 0, -1, -1, 32'h4000002C, 2'b00, 1'b1, 32'h30000020, 0, 2};

    reset       = 1'b0;
    ifu.arvalid = 1'b0;
    ifu.araddr  = '0;
    ifu.rready  = 1'b0;
    #12;
    check("rst_s_arready", 32'(ifu.arready), 32'd1);
    check("rst_s_rvalid", 32'(ifu.rvalid), 32'd0);
    check("rst_s_rdata", ifu.rdata, 32'd0);
    check("rst_s_rresp", 32'(ifu.rresp), 32'd0);
    check("rst_m_arvalid", 32'(mem.arvalid), 32'd0);
    check("rst_m_rready", 32'(mem.rready), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Asynchronous reset while beat 1 of a refill is on the bus.
    ar_delay    = 0;
    ifu.araddr  = 32'h30000040;
    ifu.arvalid = 1'b1;
    @(posedge clock); #1;
    ifu.arvalid = 1'b0;
    n = 0;
    while (cur_beat != 1 && n < 50) begin @(posedge clock); #3; n++; end
    check("rst_mid_beat1", 32'(cur_beat), 32'd1);
    check("rst_mid_rready_before", 32'(mem.rready), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_m_rready", 32'(mem.rready), 32'd0);
    check("rst_mid_s_rvalid", 32'(ifu.rvalid), 32'd0);
    check("rst_mid_s_arready", 32'(ifu.arready), 32'd1);
    check("rst_mid_m_arvalid", 32'(mem.arvalid), 32'd0);
    check("rst_mid_miss_cnt", miss_cnt, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_rel_s_arready", 32'(ifu.arready), 32'd1);
    check("rst_rel_s_rvalid", 32'(ifu.rvalid), 32'd0);
    for (int i = 0; i < 2; i++) run_vec(post[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
